sram_bus_arbiter: RTL and testbench

Arbitrates the core's instruction-fetch and data-access SRAM-like request interfaces onto one shared SRAM-like port toward the bus bridge. Both sides use the same req / addr_ok / data_ok split-transaction handshake. The block selects one requester per address phase and holds that grant stable until accepted. It records the source of every accepted request in order and routes each returning data_ok/rdata to the source that issued it.

---
 rtl/sram_bus_arbiter_pkg.sv | 19 +
 rtl/sram_bus_arbiter_if.sv | 26 ++
 rtl/sram_bus_arbiter_src_fifo.sv | 57 +++++
 rtl/sram_bus_arbiter.sv | 124 ++++++++++++
 tb/tb_sram_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared definitions for the SRAM-like bus arbiter: source IDs, access sizes
// and bus widths.
package bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// One SRAM-like split-transaction port (req / addr_ok / data_ok).
// The master issues requests and the slave answers them.
interface sram_bus_arbiter_if;
    import bus_pkg::*;

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_bus_arbiter_src_fifo.sv
// In-order record of which source issued each accepted transaction.
// A push is taken when full only if a pop happens in the same cycle.
module src_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] slots;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign head    = slots[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= din;
                wr_ptr        <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Merges the fetch and load/store SRAM-like ports onto one shared port,
// holding a stalled grant and routing in-order responses back to their issuer.
module sram_bus_arbiter
    import bus_pkg::*;
#(
    parameter int OUTSTANDING    = 2,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    sram_bus_arbiter_if.slave  inst_bus,
    sram_bus_arbiter_if.slave  data_bus,
    sram_bus_arbiter_if.master mem_bus,
    output logic               spurious_rsp
);

    localparam int                  STREAK_W   = $clog2(MAX_DATA_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_BURST);

    logic                lock_vld;
    src_e                lock_src;
    logic [STREAK_W-1:0] streak;

    logic sel_vld;
    src_e sel_src;
    logic accept;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_head;

    src_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_src_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (fifo_pop),
        .din   (sel_src),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_pop     = mem_bus.data_ok && !fifo_empty;
    assign spurious_rsp = mem_bus.data_ok && fifo_empty;

    // A pop in this cycle frees a slot, so a full FIFO can still grant.
    always_comb begin
        sel_vld = 1'b0;
        sel_src = SRC_INST;
        if (lock_vld) begin
            sel_vld = 1'b1;
            sel_src = lock_src;
        end else if (!(fifo_full && !fifo_pop)) begin
            if (inst_bus.req && data_bus.req && streak == STREAK_MAX) begin
                sel_vld = 1'b1;
                sel_src = SRC_INST;
            end else if (data_bus.req) begin
                sel_vld = 1'b1;
                sel_src = SRC_DATA;
            end else if (inst_bus.req) begin
                sel_vld = 1'b1;
                sel_src = SRC_INST;
            end
        end
    end

    always_comb begin
        mem_bus.req   = 1'b0;
        mem_bus.wr    = 1'b0;
        mem_bus.size  = '0;
        mem_bus.wstrb = '0;
        mem_bus.addr  = '0;
        mem_bus.wdata = '0;
        if (sel_vld) begin
            if (sel_src == SRC_DATA) begin
                mem_bus.req   = data_bus.req;
                mem_bus.wr    = data_bus.wr;
                mem_bus.size  = data_bus.size;
                mem_bus.wstrb = data_bus.wstrb;
                mem_bus.addr  = data_bus.addr;
                mem_bus.wdata = data_bus.wdata;
            end else begin
                mem_bus.req   = inst_bus.req;
                mem_bus.wr    = inst_bus.wr;
                mem_bus.size  = inst_bus.size;
                mem_bus.wstrb = inst_bus.wstrb;
                mem_bus.addr  = inst_bus.addr;
                mem_bus.wdata = inst_bus.wdata;
            end
        end
    end

    assign accept = mem_bus.req && mem_bus.addr_ok;

    assign inst_bus.addr_ok = accept && (sel_src == SRC_INST);
    assign data_bus.addr_ok = accept && (sel_src == SRC_DATA);
    assign inst_bus.data_ok = fifo_pop && (src_e'(fifo_head) == SRC_INST);
    assign data_bus.data_ok = fifo_pop && (src_e'(fifo_head) == SRC_DATA);
    assign inst_bus.rdata   = mem_bus.rdata;
    assign data_bus.rdata   = mem_bus.rdata;

    // A stalled request keeps its grant; the lock lapses on accept or when the
    // holder withdraws, since mem_req then follows that withdrawn req.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld <= 1'b0;
            lock_src <= SRC_INST;
            streak   <= '0;
        end else begin
            lock_vld <= mem_bus.req && !mem_bus.addr_ok;
            if (mem_bus.req && !mem_bus.addr_ok) begin
                lock_src <= sel_src;
            end
            if (!inst_bus.req || (accept && sel_src == SRC_INST)) begin
                streak <= '0;
            end else if (accept && sel_src == SRC_DATA && streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomised and directed bench for sram_bus_arbiter with a transaction-level
// reference model and a response scoreboard.
module tb_sram_bus_arbiter;
    import bus_pkg::*;

    localparam int OUTSTANDING    = 2;
    localparam int MAX_DATA_BURST = 4;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } rq_t;

    // kind is one-hot {inst_data_ok, data_data_ok, spurious_rsp}
    typedef struct {
        logic [2:0]  kind;
        logic [31:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spurious_rsp;

    sram_bus_arbiter_if inst_bus ();
    sram_bus_arbiter_if data_bus ();
    sram_bus_arbiter_if mem_bus ();

    sram_bus_arbiter #(
        .OUTSTANDING    (OUTSTANDING),
        .MAX_DATA_BURST (MAX_DATA_BURST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_bus     (inst_bus),
        .data_bus     (data_bus),
        .mem_bus      (mem_bus),
        .spurious_rsp (spurious_rsp)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int   model_q[$];
    int   model_lock = -1;
    int   model_streak = 0;
    rsp_t exp_rsp_q[$];

    logic  exp_mem_req;
    rq_t   exp_mem;
    logic  exp_inst_aok;
    logic  exp_data_aok;
    logic  acc_i;
    logic  acc_d;
    string act_log;

    rq_t   idle = '0;
    logic [2:0] mon_got;
    rsp_t  mon_exp;

    task automatic checkValue(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic driveInputs(input rq_t i, input rq_t d, input logic aok, input logic dok,
                               input logic [31:0] rd);
        inst_bus.req   = i.req;
        inst_bus.wr    = i.wr;
        inst_bus.size  = i.size;
        inst_bus.wstrb = i.wstrb;
        inst_bus.addr  = i.addr;
        inst_bus.wdata = i.wdata;
        data_bus.req   = d.req;
        data_bus.wr    = d.wr;
        data_bus.size  = d.size;
        data_bus.wstrb = d.wstrb;
        data_bus.addr  = d.addr;
        data_bus.wdata = d.wdata;
        mem_bus.addr_ok = aok;
        mem_bus.data_ok = dok;
        mem_bus.rdata   = rd;
    endtask

    task automatic checkOutput();
        checkValue("mem_req", 96'(mem_bus.req), 96'(exp_mem_req));
        checkValue("mem_fields",
                   96'({mem_bus.wr, mem_bus.size, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata}),
                   96'({exp_mem.wr, exp_mem.size, exp_mem.wstrb, exp_mem.addr, exp_mem.wdata}));
        checkValue("addr_ok", 96'({inst_bus.addr_ok, data_bus.addr_ok}),
                   96'({exp_inst_aok, exp_data_aok}));
        if (inst_bus.addr_ok) act_log = {act_log, "I"};
        if (data_bus.addr_ok) act_log = {act_log, "D"};
    endtask

    // One clock of stimulus: the model decides the grant from the arbitration
    // rules, queues the expected response, then state advances after checking.
    task automatic applyStimulus(input rq_t i, input rq_t d, input logic aok, input logic dok,
                                 input logic [31:0] rd);
        int   granted;
        logic pop;
        logic full;
        logic accepted;
        rq_t  sel;
        @(posedge clk);
        #1;
        driveInputs(i, d, aok, dok, rd);
        pop  = dok && (model_q.size() > 0);
        full = (model_q.size() == OUTSTANDING) && !pop;
        granted = -1;
        if (model_lock >= 0) granted = model_lock;
        else if (!full) begin
            if (i.req && d.req) granted = (model_streak >= MAX_DATA_BURST) ? 0 : 1;
            else if (d.req) granted = 1;
            else if (i.req) granted = 0;
        end
        sel          = (granted == 1) ? d : i;
        exp_mem_req  = (granted >= 0) && sel.req;
        exp_mem      = (granted >= 0) ? sel : '0;
        accepted     = exp_mem_req && aok;
        exp_inst_aok = accepted && (granted == 0);
        exp_data_aok = accepted && (granted == 1);
        if (dok) begin
            if (model_q.size() == 0) exp_rsp_q.push_back('{kind: 3'b001, rdata: 32'h0});
            else exp_rsp_q.push_back('{kind: (model_q[0] == 0) ? 3'b100 : 3'b010, rdata: rd});
        end
        @(negedge clk);
        checkOutput();
        if (pop) void'(model_q.pop_front());
        if (accepted) model_q.push_back(granted);
        model_lock = (exp_mem_req && !aok) ? granted : -1;
        if (!i.req || (accepted && granted == 0)) model_streak = 0;
        else if (accepted && granted == 1 && model_streak < MAX_DATA_BURST) model_streak++;
        acc_i = exp_inst_aok;
        acc_d = exp_data_aok;
    endtask

    task automatic doReset(input int cycles);
        @(posedge clk);
        #1;
        rst = 1'b1;
        driveInputs(idle, idle, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            checkValue("reset_mem_req", 96'(mem_bus.req), 96'(0));
            checkValue("reset_mem_fields",
                       96'({mem_bus.wr, mem_bus.size, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata}),
                       96'(0));
            checkValue("reset_oks", 96'({inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok,
                                          data_bus.data_ok, spurious_rsp}), 96'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_q.delete();
        model_lock   = -1;
        model_streak = 0;
    endtask

    task automatic newReq(output rq_t r, input bit is_inst);
        r.req   = ($urandom_range(0, 3) != 0);
        r.wr    = is_inst ? 1'b0 : 1'($urandom_range(0, 1));
        r.size  = 2'($urandom_range(0, 2));
        r.wstrb = 4'($urandom);
        r.addr  = $urandom;
        r.wdata = $urandom;
    endtask

    // Response scoreboard: every DUT response must match the queued expectation.
    always @(negedge clk) begin
        mon_got = {inst_bus.data_ok, data_bus.data_ok, spurious_rsp};
        if (mon_got != 3'b000) begin
            if (exp_rsp_q.size() == 0) begin
                checkValue("rsp_unexpected", 96'(mon_got), 96'(0));
            end else begin
                mon_exp = exp_rsp_q.pop_front();
                checkValue("rsp_kind", 96'(mon_got), 96'(mon_exp.kind));
                if (mon_exp.kind != 3'b001)
                    checkValue("rsp_rdata", 96'({inst_bus.rdata, data_bus.rdata}),
                               96'({mon_exp.rdata, mon_exp.rdata}));
            end
        end else if (exp_rsp_q.size() != 0) begin
            mon_exp = exp_rsp_q.pop_front();
            checkValue("rsp_missing", 96'(mon_got), 96'(mon_exp.kind));
        end
    end

    initial begin
        rq_t ri;
        rq_t rd;
        rq_t fi;
        rq_t fd;
        logic aok;
        logic dok;

        driveInputs(idle, idle, 1'b0, 1'b0, 32'h0);
        doReset(2);

        // lone fetch
        fi = '{req: 1'b1, wr: 1'b0, size: SIZE_W, wstrb: 4'hF, addr: 32'h1C00_0000, wdata: 32'h0};
        applyStimulus(fi, idle, 1'b1, 1'b0, 32'h0);
        applyStimulus(idle, idle, 1'b0, 1'b0, 32'h0);
        applyStimulus(idle, idle, 1'b0, 1'b1, 32'h1234_5678);

        // priority and lock: stalled DATA keeps its grant while INST joins
        fd = '{req: 1'b1, wr: 1'b1, size: SIZE_W, wstrb: 4'hF, addr: 32'h8000_0040, wdata: 32'hDEAD_BEEF};
        fi = '{req: 1'b1, wr: 1'b0, size: SIZE_W, wstrb: 4'hF, addr: 32'h1C00_0004, wdata: 32'h0};
        applyStimulus(idle, fd, 1'b0, 1'b0, 32'h0);
        applyStimulus(fi, fd, 1'b0, 1'b0, 32'h0);
        applyStimulus(fi, fd, 1'b0, 1'b0, 32'h0);
        applyStimulus(fi, fd, 1'b1, 1'b0, 32'h0);
        applyStimulus(fi, idle, 1'b1, 1'b0, 32'h0);
        applyStimulus(idle, idle, 1'b0, 1'b1, 32'hAAAA_0001);
        applyStimulus(idle, idle, 1'b0, 1'b1, 32'hAAAA_0002);

        // fairness
        act_log = "";
        for (int n = 0; n < 10; n++)
            applyStimulus(fi, fd, 1'b1, model_q.size() > 0, $urandom);
        checks++;
        if (act_log != "DDDDIDDDDI") begin
            failures++;
            $display("[TB] FAIL grant_sequence: got %s expected DDDDIDDDDI", act_log);
        end
        applyStimulus(idle, idle, 1'b0, 1'b1, 32'hBBBB_0000);

        // ordering and full FIFO
        applyStimulus(fi, idle, 1'b1, 1'b0, 32'h0);
        applyStimulus(idle, fd, 1'b1, 1'b0, 32'h0);
        applyStimulus(fi, fd, 1'b1, 1'b0, 32'h0);
        applyStimulus(fi, fd, 1'b1, 1'b1, 32'hC0DE_0001);
        applyStimulus(fi, fd, 1'b1, 1'b0, 32'h0);
        applyStimulus(idle, idle, 1'b0, 1'b1, 32'hC0DE_0002);
        applyStimulus(idle, idle, 1'b0, 1'b1, 32'hC0DE_0003);

        // spurious response
        applyStimulus(idle, idle, 1'b0, 1'b1, 32'hFFFF_0000);

        // reset with two outstanding
        applyStimulus(fi, idle, 1'b1, 1'b0, 32'h0);
        applyStimulus(idle, fd, 1'b1, 1'b0, 32'h0);
        doReset(1);
        applyStimulus(idle, idle, 1'b0, 1'b1, 32'h5555_0001);
        applyStimulus(idle, idle, 1'b0, 1'b1, 32'h5555_0002);

        // randomised traffic
        newReq(ri, 1'b1);
        newReq(rd, 1'b0);
        for (int n = 0; n < 400; n++) begin
            aok = ($urandom_range(0, 9) < 7);
            dok = (model_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
            applyStimulus(ri, rd, aok, dok, $urandom);
            if (acc_i || !ri.req || $urandom_range(0, 9) == 0) newReq(ri, 1'b1);
            if (acc_d || !rd.req || $urandom_range(0, 9) == 0) newReq(rd, 1'b0);
        end
        for (int n = 0; n < OUTSTANDING; n++)
            applyStimulus(idle, idle, 1'b0, model_q.size() > 0, $urandom);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
